// File: rtl/sram_arbiter_2m.sv
// sram_arbiter_2m: round-robin two-master sequencer for the SRAM controller; SRAM_ARB_TIMEOUT_EN adds a WAIT watchdog
module sram_arbiter_2m #(
  parameter int ADDR_W         = 18,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_M0_REQ,
  input  logic                i_M0_WE,
  input  logic [ADDR_W-1:0]   i_M0_ADDR,
  input  logic [DATA_W-1:0]   i_M0_WDATA,
  input  logic [DATA_W/8-1:0] i_M0_BMASK,
  output logic [DATA_W-1:0]   o_M0_RDATA,
  output logic                o_M0_ACK,
  input  logic                i_M1_REQ,
  input  logic                i_M1_WE,
  input  logic [ADDR_W-1:0]   i_M1_ADDR,
  input  logic [DATA_W-1:0]   i_M1_WDATA,
  input  logic [DATA_W/8-1:0] i_M1_BMASK,
  output logic [DATA_W-1:0]   o_M1_RDATA,
  output logic                o_M1_ACK,
  output logic                o_ERR,
  output logic [ADDR_W-1:0]   o_ADDR,
  output logic [DATA_W-1:0]   o_WDATA,
  output logic [DATA_W/8-1:0] o_BMASK,
  output logic                o_WREN,
  output logic                o_RDEN,
  input  logic [DATA_W-1:0]   i_RDATA,
  input  logic                i_ACK
);
  localparam int BW = DATA_W / 8;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t            state_q, state_d;
  logic              last_q, last_d, gnt_q, gnt_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rd0_q, rd0_d, rd1_q, rd1_d;
  logic [BW-1:0]     bmask_q, bmask_d;
  logic              win1, tmo, cap;
  logic [DATA_W-1:0] cap_data;
  assign win1     = i_M1_REQ & (~i_M0_REQ | ~last_q);
  assign cap      = (state_q == WAIT) & (i_ACK | tmo);
  assign cap_data = i_ACK ? i_RDATA : DATA_W'(32'hDEAD_BEEF);
  // next state, grant latch and per-master read data capture
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    bmask_d = bmask_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    if (state_q == IDLE && (i_M0_REQ | i_M1_REQ)) begin
      state_d = ISSUE;
      last_d  = win1;
      gnt_d   = win1;
      we_d    = win1 ? i_M1_WE : i_M0_WE;
      addr_d  = (win1 ? i_M1_ADDR : i_M0_ADDR) & ~ADDR_W'(1);
      wdata_d = win1 ? i_M1_WDATA : i_M0_WDATA;
      bmask_d = win1 ? i_M1_BMASK : i_M0_BMASK;
    end
    if (state_q == ISSUE) state_d = WAIT;
    if (cap) begin
      state_d = RESP;
      rd0_d   = gnt_q ? rd0_q : cap_data;
      rd1_d   = gnt_q ? cap_data : rd1_q;
    end
    if (state_q == RESP) state_d = IDLE;
  end
  // state and request register; reset drops any transaction and favours M0
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      bmask_q <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      bmask_q <= bmask_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end
`ifdef SRAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  assign tmo   = (state_q == WAIT) & (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign o_ERR = (state_q == RESP) & err_q;
  // watchdog counts WAIT cycles; a late ack on the limit cycle still completes normally
  always_comb begin
    cnt_d = (state_q == WAIT) ? cnt_q + CW'(1) : '0;
    err_d = cap ? ~i_ACK : err_q;
  end
  // watchdog registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  assign tmo   = 1'b0;
  assign o_ERR = 1'b0;
`endif
  assign o_WREN     = (state_q == ISSUE) & we_q;
  assign o_RDEN     = (state_q == ISSUE) & ~we_q;
  assign o_M0_ACK   = (state_q == RESP) & ~gnt_q;
  assign o_M1_ACK   = (state_q == RESP) & gnt_q;
  assign o_M0_RDATA = rd0_q;
  assign o_M1_RDATA = rd1_q;
  assign o_ADDR     = addr_q;
  assign o_WDATA    = wdata_q;
  assign o_BMASK    = bmask_q;
endmodule
